sram_bridge_sync: RTL

Clocked bridge from the ARM static-memory bus to an external SRAM that is narrower than the ARM bus. Each ARM access is split into RATIO = ARM_DW/SRAM_DW sequential SRAM cycles with programmable strobe width. ARM_NWAIT stretches the ARM cycle until the access completes. Sits in the FPGA between the ARM EBI pins and the SRAM pins.

---
 rtl/sram_bridge_pkg.sv | 16 +
 rtl/sync_2ff.sv | 15 +
 rtl/sram_bridge_sync.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg: FSM states and width helpers for the ARM-to-narrow-SRAM bridge
package sram_bridge_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction
  function automatic int ratio(input int arm_dw, input int sram_dw);
    return arm_dw / sram_dw;
  endfunction
  function automatic int lane_w(input int r);
    return (clog2(r) > 0) ? clog2(r) : 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous bit, d_i in, q_o out, resets to RST_VAL
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk)
    if (rst) ff_q <= {2{RST_VAL}};
    else ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/sram_bridge_sync.sv
// sram_bridge_sync: splits each ARM static-memory access into RATIO narrow SRAM cycles
// Ports: CLK/RST (sync, active high); ARM_D/A/NBE/CS/OE/WE from the EBI, ARM_NWAIT back to it;
// SRAM_D/A/CS/OE/WE to the SRAM. Define ACCESS_STATS_EN to add STAT_RD/STAT_WR access counters.
module sram_bridge_sync
  import sram_bridge_pkg::*;
#(
  parameter int ARM_DW      = 16,
  parameter int SRAM_DW     = 8,
  parameter int ARM_AW      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                                        CLK,
  input  logic                                        RST,
  inout  wire  [ARM_DW-1:0]                           ARM_D,
  input  logic [ARM_AW-1:0]                           ARM_A,
  input  logic [ARM_DW/8-1:0]                         ARM_NBE,
  input  logic                                        ARM_CS,
  input  logic                                        ARM_OE,
  input  logic                                        ARM_WE,
  output logic                                        ARM_NWAIT,
  inout  wire  [SRAM_DW-1:0]                          SRAM_D,
  output logic [ARM_AW+clog2(ARM_DW/SRAM_DW)-1:0]     SRAM_A,
  output logic                                        SRAM_CS,
  output logic                                        SRAM_OE,
  output logic                                        SRAM_WE
`ifdef ACCESS_STATS_EN
  ,
  output logic [31:0]                                 STAT_RD,
  output logic [31:0]                                 STAT_WR
`endif
);
  localparam int RATIO = ratio(ARM_DW, SRAM_DW);
  localparam int LW    = clog2(RATIO);
  localparam int LCW   = lane_w(RATIO);
  localparam int BPL   = SRAM_DW / 8;
  localparam int SAW   = ARM_AW + LW;
  localparam logic [3:0] CW = 4'(WAIT_CYCLES);
  state_e             state_q, state_d;
  logic [LCW-1:0]     lane_q, lane_d, hit_lane;
  logic [3:0]         cnt_q, cnt_d;
  logic               armed_q, armed_d, nwait_d, cs_d, oe_d, we_d;
  logic               cs_s, oe_s, we_s, accept, hit, op_wr;
  logic [ARM_AW-1:0]  addr_q;
  logic [ARM_DW/8-1:0] nbe_q, src_nbe;
  logic [ARM_DW-1:0]  wdata_q, rdata_q;
  logic               wr_q;
  int                 start;
  sync_2ff u_sync_cs (.clk(CLK), .rst(RST), .d_i(ARM_CS), .q_o(cs_s));
  sync_2ff u_sync_oe (.clk(CLK), .rst(RST), .d_i(ARM_OE), .q_o(oe_s));
  sync_2ff u_sync_we (.clk(CLK), .rst(RST), .d_i(ARM_WE), .q_o(we_s));
  // In IDLE the lane search looks at the live byte enables, since they are latched on the same edge.
  always_comb begin
    src_nbe  = (state_q == IDLE) ? ARM_NBE : nbe_q;
    start    = (state_q == IDLE) ? 0 : int'(lane_q) + 1;
    hit      = 1'b0;
    hit_lane = '0;
    for (int i = RATIO - 1; i >= 0; i--)
      if (i >= start && !(&src_nbe[i*BPL +: BPL])) begin
        hit      = 1'b1;
        hit_lane = LCW'(i);
      end
    accept  = state_q == IDLE && armed_q && !cs_s && (!oe_s || !we_s);
    op_wr   = (state_q == IDLE) ? !we_s : wr_q;
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (accept) begin
                 state_d = hit ? SETUP : DONE;
                 lane_d  = hit_lane;
               end
      SETUP:   begin
                 state_d = STROBE;
                 cnt_d   = '0;
               end
      STROBE:  begin
                 state_d = (cnt_q == CW) ? HOLD : STROBE;
                 cnt_d   = cnt_q + 4'd1;
               end
      HOLD:    begin
                 state_d = hit ? SETUP : DONE;
                 lane_d  = hit ? hit_lane : lane_q;
               end
      DONE:    state_d = cs_s ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    armed_d = !accept && (armed_q || cs_s);
    // NWAIT rises one clock after DONE is reached, giving the +1 in the low time.
    nwait_d = state_q == DONE || (state_q == IDLE && !accept);
    cs_d    = !(state_d inside {SETUP, STROBE, HOLD});
    oe_d    = !(state_d == STROBE && !op_wr);
    we_d    = !(state_d == STROBE && op_wr);
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      addr_q    <= '0;
      nbe_q     <= '1;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_q      <= 1'b0;
      ARM_NWAIT <= 1'b1;
      SRAM_CS   <= 1'b1;
      SRAM_OE   <= 1'b1;
      SRAM_WE   <= 1'b1;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      ARM_NWAIT <= nwait_d;
      SRAM_CS   <= cs_d;
      SRAM_OE   <= oe_d;
      SRAM_WE   <= we_d;
      if (accept) begin
        addr_q  <= ARM_A;
        nbe_q   <= ARM_NBE;
        wdata_q <= ARM_D;
        rdata_q <= '0;
        wr_q    <= !we_s;
      end
      if (state_q == STROBE && cnt_q == CW && !wr_q) rdata_q[lane_q*SRAM_DW +: SRAM_DW] <= SRAM_D;
    end
  assign SRAM_A = (SAW'(addr_q) << LW) | SAW'(lane_q);
  assign SRAM_D = (wr_q && state_q inside {SETUP, STROBE, HOLD}) ? wdata_q[lane_q*SRAM_DW +: SRAM_DW] : 'z;
  assign ARM_D  = (!wr_q && state_q == DONE && !ARM_OE && !ARM_CS) ? rdata_q : 'z;
`ifdef ACCESS_STATS_EN
  always_ff @(posedge CLK)
    if (RST) begin
      STAT_RD <= '0;
      STAT_WR <= '0;
    end else if (state_d == DONE && state_q != DONE) begin
      STAT_WR <= STAT_WR + 32'(op_wr);
      STAT_RD <= STAT_RD + 32'(!op_wr);
    end
`endif
endmodule
